// File: rtl/controlador_acumulador_pkg.sv
// Shared types and datapath sizing for the accumulator controller and its datapath.
package pkg_controle;

    localparam int WIDTH_DP = 4;
    localparam int CNT_W_DP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } estado_t;

endpackage : pkg_controle

// File: rtl/controlador_acumulador_if.sv
// Controller <-> adder/register datapath bus.
interface controlador_acumulador_if #(
    parameter int WIDTH = pkg_controle::WIDTH_DP
);
    logic [WIDTH-1:0] operando_a;
    logic             sel_mux;
    logic             enable;
    logic [WIDTH-1:0] resultado;

    // Controller side: drives operand A, term select and load enable.
    modport master (
        output operando_a,
        output sel_mux,
        output enable,
        input  resultado
    );

    // Datapath side: accumulates and returns its register value.
    modport slave (
        input  operando_a,
        input  sel_mux,
        input  enable,
        output resultado
    );
endinterface : controlador_acumulador_if

// File: rtl/controlador_acumulador_contador_passos.sv
// Loadable down-counter tracking remaining accumulate steps.
module contador_passos
    import pkg_controle::*;
#(
    parameter int CNT_W = CNT_W_DP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_valor,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_valor;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : contador_passos

// File: rtl/saida.sv
// Adder + register datapath: reg <= A + (sel_mux ? C : B) whenever enable is high.
module saida
    import pkg_controle::*;
#(
    parameter int WIDTH = WIDTH_DP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       entradaB,
    input  logic [WIDTH-1:0]       entradaC,
    controlador_acumulador_if.slave dp
);

    logic [WIDTH-1:0] r_registrador;
    logic [WIDTH-1:0] w_termo;

    assign w_termo = dp.sel_mux ? entradaC : entradaB;

    // Accumulator register; the sum wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_registrador <= '0;
        end else if (dp.enable) begin
            r_registrador <= dp.operando_a + w_termo;
        end
    end

    assign dp.resultado = r_registrador;

endmodule : saida

// File: rtl/controlador_acumulador.sv
// Sequencer for the saida datapath: runs n accumulate steps and reports the sum.
module controlador_acumulador
    import pkg_controle::*;
#(
    parameter int WIDTH = WIDTH_DP,
    parameter int CNT_W = CNT_W_DP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         n_passos,
    input  logic                     sel_origem,
    controlador_acumulador_if.master dp,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         acumulado
);

    estado_t          r_estado;
    logic             r_enable;
    logic             r_sel_mux;
    logic             r_busy;
    logic             r_done;
    logic             r_n_zero;
    logic [WIDTH-1:0] r_acumulado;

    logic             w_aceita;
    logic             w_load;
    logic [CNT_W-1:0] w_valor;
    logic             w_dec;
    logic             w_zero;

    assign w_aceita = (r_estado == IDLE) && start;
    assign w_load   = w_aceita && (n_passos != '0);
    assign w_valor  = n_passos - CNT_W'(1);
    assign w_dec    = ((r_estado == INIT) || (r_estado == ACCUM)) && !w_zero;

    // Counter holds the steps still to run after the current one (n-1 at INIT).
    contador_passos #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_valor (w_valor),
        .i_dec   (w_dec),
        .o_zero  (w_zero)
    );

    // Control FSM; enable/sel/busy are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado    <= IDLE;
            r_enable    <= 1'b0;
            r_sel_mux   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_n_zero    <= 1'b0;
            r_acumulado <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (w_aceita) begin
                        r_busy    <= 1'b1;
                        r_sel_mux <= sel_origem;
                        r_n_zero  <= (n_passos == '0);
                        if (n_passos != '0) begin
                            r_estado <= INIT;
                            r_enable <= 1'b1;
                        end else begin
                            r_estado <= DONE;
                        end
                    end
                end
                INIT, ACCUM: begin
                    if (w_zero) begin
                        r_estado <= DONE;
                        r_enable <= 1'b0;
                    end else begin
                        r_estado <= ACCUM;
                    end
                end
                DONE: begin
                    r_estado    <= IDLE;
                    r_busy      <= 1'b0;
                    r_sel_mux   <= 1'b0;
                    r_done      <= 1'b1;
                    r_acumulado <= r_n_zero ? '0 : dp.resultado;
                end
                default: begin
                    r_estado <= IDLE;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    // Operand A must track the live register value during ACCUM, so it is a
    // pass-through of the feedback rather than a registered copy.
    assign dp.operando_a = (r_estado == ACCUM) ? dp.resultado : '0;
    assign dp.enable     = r_enable;
    assign dp.sel_mux    = r_sel_mux;
    assign busy          = r_busy;
    assign done          = r_done;
    assign acumulado     = r_acumulado;

endmodule : controlador_acumulador
